// File: rtl/dap_pkg.sv
// Shared DAP worker definitions: status bytes and the worker state encoding.
package dap_pkg;
  localparam logic [7:0] DAP_OK    = 8'h00;
  localparam logic [7:0] DAP_ERROR = 8'hFF;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } dap_state_e;
endpackage

// File: rtl/dap_delay_timer_if.sv
// Operand byte stream in, status byte stream out.
interface dap_delay_timer_if;
  logic       dap_in_tvalid;
  logic       dap_in_tready;
  logic [7:0] dap_in_tdata;
  logic       dap_out_tvalid;
  logic       dap_out_tready;
  logic [7:0] dap_out_tdata;

  modport master (
    output dap_in_tvalid, dap_in_tdata, dap_out_tready,
    input  dap_in_tready, dap_out_tvalid, dap_out_tdata
  );
  modport slave (
    input  dap_in_tvalid, dap_in_tdata, dap_out_tready,
    output dap_in_tready, dap_out_tvalid, dap_out_tdata
  );
endinterface

// File: rtl/dap_us_prescaler.sv
// Divides hclk down to a one-cycle microsecond tick while run is high.
module dap_us_prescaler #(
  parameter int DIV = 60
) (
  input  logic hclk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;

  // Combinational pulse so the decrement lands in the same cycle as the wrap.
  assign tick = run & (pre == PW'(DIV - 1));

  always_ff @(posedge hclk) begin
    if (rst || clr || !run) pre <= '0;
    else if (tick)          pre <= '0;
    else                    pre <= pre + 1'b1;
  end
endmodule

// File: rtl/dap_delay_timer.sv
// DAP_Delay worker: assembles a little-endian delay operand, waits that many
// microsecond ticks, then returns one status byte.
module dap_delay_timer
  import dap_pkg::*;
#(
  parameter int                       DELAY_BYTES = 2,
  parameter int                       TICK_DIV    = 60,
  parameter logic [8*DELAY_BYTES-1:0] MAX_DELAY   = '1
) (
  input  logic               hclk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               us_tick,
  dap_delay_timer_if.slave   bus,
  output logic               done,
  output logic               busy
);
  localparam int         W    = 8 * DELAY_BYTES;
  localparam logic [2:0] LAST = 3'(DELAY_BYTES - 1);

  dap_state_e     state, state_d;
  logic [2:0]     idx, idx_d;
  logic [W-1:0]   count, count_d, asm;
  logic           err, err_d;
  logic           tvalid, tvalid_d;
  logic [7:0]     tdata, tdata_d;
  logic           abort, xfer, tick, pre_clr, over_max;

  assign abort             = rst | ~en | ~start;
  assign bus.dap_in_tready = en & start & (state == ST_RX);
  assign bus.dap_out_tvalid = tvalid;
  assign bus.dap_out_tdata  = tdata;
  assign busy              = (state == ST_WAIT);
  assign done              = (state == ST_DONE);
  assign xfer              = bus.dap_in_tvalid & bus.dap_in_tready;

  always_comb begin
    asm = count;
    for (int b = 0; b < DELAY_BYTES; b++)
      if (idx == 3'(b)) asm[8*b +: 8] = bus.dap_in_tdata;
  end

  // An all-ones limit can never be exceeded; skip the compare entirely.
  generate
    if (MAX_DELAY == '1) begin : g_nolimit
      assign over_max = 1'b0;
    end else begin : g_limit
      assign over_max = (asm > MAX_DELAY);
    end
  endgenerate

  generate
    if (TICK_DIV == 0) begin : g_ext_tick
      logic unused_clr;
      assign unused_clr = pre_clr;
      assign tick       = us_tick;
    end else begin : g_int_tick
      logic unused_tick;
      assign unused_tick = us_tick;
      dap_us_prescaler #(.DIV(TICK_DIV)) u_pre (
        .hclk (hclk),
        .rst  (abort),
        .clr  (pre_clr),
        .run  (state == ST_WAIT),
        .tick (tick)
      );
    end
  endgenerate

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    count_d  = count;
    err_d    = err;
    tvalid_d = tvalid;
    tdata_d  = tdata;
    pre_clr  = 1'b0;
    case (state)
      ST_RX: if (xfer) begin
        count_d = asm;
        idx_d   = idx + 3'd1;
        if (idx == LAST) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          err_d   = over_max;
          pre_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (err) begin
          state_d  = ST_RESP;
          tvalid_d = 1'b1;
          tdata_d  = DAP_ERROR;
        end else if (count == '0) begin
          state_d  = ST_RESP;
          tvalid_d = 1'b1;
          tdata_d  = DAP_OK;
        end else if (tick) begin
          count_d = count - W'(1);
        end
      end
      ST_RESP: if (bus.dap_out_tready) begin
        state_d  = ST_DONE;
        tvalid_d = 1'b0;
      end
      default: ;
    endcase
    if (abort) begin
      state_d  = ST_RX;
      idx_d    = '0;
      count_d  = '0;
      err_d    = 1'b0;
      tvalid_d = 1'b0;
      tdata_d  = 8'h00;
    end
  end

  always_ff @(posedge hclk) begin
    state  <= state_d;
    idx    <= idx_d;
    count  <= count_d;
    err    <= err_d;
    tvalid <= tvalid_d;
    tdata  <= tdata_d;
  end
endmodule

// File: doc/dap_delay_timer.md
# dap_delay_timer

Parametrised DAP_Delay command worker for the DAP controller's cmd_worker group. It consumes a little-endian delay operand of configurable width from the command byte stream, then waits that many microsecond ticks. It returns a single status byte over a back-pressured output stream. The tick comes from an internal hclk prescaler or an external us_tick. Out-of-range operands are rejected immediately, and the worker supports abort and restart.

## Interface
- DELAY_BYTES, 2: operand length in bytes (1..4); counter width W = 8*DELAY_BYTES
- TICK_DIV, 60: hclk cycles per microsecond tick; 0 selects external us_tick
- MAX_DELAY, 2**W-1: largest accepted operand; larger values return DAP_ERROR without waiting

Ports:
- hclk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  worker enable; low has the same effect as rst
- start  in  1  command select; low aborts and returns to RX
- us_tick  in  1  one-cycle tick pulse, used only when TICK_DIV=0
- dap_in_tvalid  in  1  operand byte valid
- dap_in_tready  out  1  operand byte ready
- dap_in_tdata  in  8  operand byte
- dap_out_tvalid  out  1  status byte valid
- dap_out_tready  in  1  status byte accepted
- dap_out_tdata  out  8  status byte
- done  out  1  response consumed, waiting for start to drop
- busy  out  1  state is WAIT

## Operation
- States:
  - RX: collect operand bytes.
  - WAIT: count ticks.
  - RESP: offer the status byte.
  - DONE: response consumed.
- Reset, en=0, or start=0: state goes to RX; byte index 0; count 0; err 0; dap_out_tvalid 0; dap_out_tdata 0x00; prescaler 0.
- RX:
  - dap_in_tready = en & start & (state==RX), combinational.
  - Each valid&ready transfer stores the byte at count[8*idx +: 8] and increments idx.
  - On the transfer with idx==DELAY_BYTES-1: go to WAIT, clear the prescaler, and set err = (operand > MAX_DELAY), evaluated on the fully assembled value.
- WAIT, priority order:
  - err=1: RESP with data 0xFF.
  - count==0: RESP with data 0x00.
  - Tick this cycle: count decrements by 1.
- RESP: dap_out_tvalid=1 with data stable until dap_out_tready; on the handshake go to DONE and drop tvalid.
- DONE: done=1; no further bytes accepted; leaves only via start=0.
- Internal tick: the prescaler counts 0..TICK_DIV-1 in WAIT only and pulses at TICK_DIV-1. The external tick is ignored outside WAIT.
- start dropping in any state discards partial operand or response. Data is never emitted after an abort.

## Timing
- The last operand byte is accepted at cycle c.
  - Operand 0 or error: tvalid rises at c+2.
  - Internal tick, operand N ≤ MAX_DELAY: tvalid rises at exactly c+2+N*TICK_DIV.
  - External tick: tvalid rises 2 cycles after the Nth us_tick observed in WAIT.
- tvalid to done: done is high the cycle after the tready handshake.
- Simultaneous tick and count==0: the count==0 branch wins; no underflow.
- A tick coinciding with the WAIT entry cycle counts only if TICK_DIV=0. The prescaler starts fresh on WAIT entry.
- All outputs are registered except dap_in_tready, done, and busy, which decode state.

## Structure
- Shared package dap_pkg holds:
  - DAP_OK = 8'h00 and DAP_ERROR = 8'hFF
  - the worker state enum (RX, WAIT, RESP, DONE)
- Sub-module dap_us_prescaler(hclk, rst, clr, run, tick), parameter DIV. It is bypassed via a generate branch when TICK_DIV=0.

## Test plan
- DELAY_BYTES=2, TICK_DIV=4, operand bytes 0x03,0x00 -> tvalid at c+14, data 0x00; tready held → done at next cycle.
- Operand 0x00,0x00 -> data 0x00 at c+2; busy high for exactly 1 cycle.
- MAX_DELAY=1000, operand 0xE9,0x03 (1001) -> data 0xFF at c+2, no tick consumption.
- DELAY_BYTES=3, TICK_DIV=0, operand 0x02,0x00,0x00 with us_tick every 7 cycles -> response 2 cycles after the 2nd tick in WAIT; dap_out_tready low 5 cycles → tvalid and data held, done only after the handshake.
- start dropped after the first byte, then reasserted with 0x01,0x00 -> the stale byte is discarded; a fresh delay of 1 tick is completed.
- rst pulse mid-WAIT (count 0x1234) -> next cycle state RX, tvalid 0, tready 1 while start=1.
